// File: rtl/port2axis_pkg.sv
// Shared types and helpers for the multi-channel port-to-AXI-Stream arbiter.
//   P2A_LANES / P2A_W : default flit geometry (words per flit, bits per word)
//   flit_t            : one flit, LANES x W
//   fentry_t          : FIFO entry, end-of-frame marker plus flit
//   rr_index()        : round-robin channel index (base + offset) mod n
package port2axis_pkg;

    localparam int unsigned P2A_LANES = 8;
    localparam int unsigned P2A_W     = 64;

    typedef logic [P2A_LANES-1:0][P2A_W-1:0] flit_t;

    typedef struct packed {
        logic  eof;
        flit_t data;
    } fentry_t;

    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Per-channel synchronous FIFO with registered backpressure and sticky overflow.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_valid   : incoming entry valid; accepted if not full or a read happens
//   wr_data    : incoming entry {eof, flit}
//   rd_en      : pop request (ignored while empty)
//   rd_data    : head entry (combinational read)
//   full/empty : occupancy flags
//   free       : free entries
//   bp         : registered, high when next-state free entries <= BP_SLACK
//   ovf        : sticky, an entry was dropped because the FIFO was full
module port_fifo
    import port2axis_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned BP_SLACK = 4,
    parameter int unsigned WIDTH    = $bits(fentry_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free,
    output logic                     bp,
    output logic                     ovf
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] SLACK_C = (AW+1)'(BP_SLACK);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             wr_en;
    logic             rd_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign free    = DEPTH_C - count;
    assign rd_ok   = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en   = wr_valid && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({wr_en, rd_ok})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bp     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            bp    <= ((DEPTH_C - count_next) <= SLACK_C);
            if (wr_valid && !wr_en) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/port2axis_arb.sv
// Merges CH buffered port streams onto one AXI4-Stream master with a
// frame-granular round-robin arbiter; TDEST carries the source channel.
//   CLK, RST        : clock, asynchronous active-high reset
//   D/D_VALID/D_EOF : per-channel flit input
//   D_BP            : per-channel registered backpressure
//   M_AXIS_*        : AXI4-Stream master (TDATA/TVALID/TLAST/TDEST, TREADY in)
//   OVF             : per-channel sticky overflow flag
module port2axis_arb
    import port2axis_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned LANES    = P2A_LANES,
    parameter int unsigned W        = P2A_W,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned BP_SLACK = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CH-1:0][LANES-1:0][W-1:0] D,
    input  logic [CH-1:0]                  D_VALID,
    input  logic [CH-1:0]                  D_EOF,
    output logic [CH-1:0]                  D_BP,
    output logic [LANES-1:0][W-1:0]        M_AXIS_TDATA,
    output logic                           M_AXIS_TVALID,
    output logic                           M_AXIS_TLAST,
    output logic [$clog2(CH)-1:0]          M_AXIS_TDEST,
    input  logic                           M_AXIS_TREADY,
    output logic [CH-1:0]                  OVF
);

    localparam int unsigned CW = $clog2(CH);
    localparam int unsigned FW = LANES * W + 1;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]            state;
    logic [CW-1:0]         grant;
    logic [CW-1:0]         last_grant;
    logic [CW-1:0]         scan_ch;
    logic [CW-1:0]         sel;
    logic                  scan_hit;
    logic                  eof_popped;
    logic                  reg_free;
    logic                  pop;
    logic                  pop_eof;
    logic [FW-1:0]         sel_entry;
    logic [CH-1:0]         fifo_empty;
    logic [CH-1:0]         fifo_full_unused;
    logic [CH-1:0]         fifo_rd;
    logic [$clog2(DEPTH):0] fifo_free_unused [CH];
    logic [FW-1:0]         fifo_rd_data [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        port_fifo #(
            .DEPTH    (DEPTH),
            .BP_SLACK (BP_SLACK),
            .WIDTH    (FW)
        ) u_fifo (
            .clk      (CLK),
            .rst      (RST),
            .wr_valid (D_VALID[c]),
            .wr_data  ({D_EOF[c], D[c]}),
            .rd_en    (fifo_rd[c]),
            .rd_data  (fifo_rd_data[c]),
            .full     (fifo_full_unused[c]),
            .empty    (fifo_empty[c]),
            .free     (fifo_free_unused[c]),
            .bp       (D_BP[c]),
            .ovf      (OVF[c])
        );
    end

    // First non-empty channel after the last granted one.
    always_comb begin : p_scan
        logic [CW-1:0] cand;
        cand     = '0;
        scan_ch  = '0;
        scan_hit = 1'b0;
        for (int unsigned i = 1; i <= CH; i++) begin
            cand = CW'(rr_index(32'(last_grant), i, CH));
            if (!scan_hit && !fifo_empty[cand]) begin
                scan_hit = 1'b1;
                scan_ch  = cand;
            end
        end
    end

    // The ARB cycle grants and pops the first flit on the same edge, so the
    // only bubble between frames is that single arbitration cycle.
    assign sel       = (state == ST_ARB) ? scan_ch : grant;
    assign sel_entry = fifo_rd_data[sel];
    assign pop_eof   = sel_entry[FW-1];
    assign reg_free  = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign pop       = reg_free && ((state == ST_ARB) ? scan_hit
                                    : (!eof_popped && !fifo_empty[grant]));

    always_comb begin
        fifo_rd = '0;
        if (pop) begin
            fifo_rd[sel] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_ARB;
            grant         <= '0;
            last_grant    <= CW'(CH - 1);
            eof_popped    <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TDEST  <= '0;
        end else begin
            if (pop) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= sel_entry[FW-2:0];
                M_AXIS_TLAST  <= pop_eof;
                M_AXIS_TDEST  <= sel;
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end

            case (state)
                ST_ARB: begin
                    if (pop) begin
                        state      <= ST_XFER;
                        grant      <= scan_ch;
                        eof_popped <= pop_eof;
                    end
                end
                default: begin
                    // Stop popping once the EOF flit is in the register; the
                    // grant is released only after that flit is accepted.
                    if (pop && pop_eof) begin
                        eof_popped <= 1'b1;
                    end
                    if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
                        state      <= ST_ARB;
                        last_grant <= grant;
                        eof_popped <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port2axis_arb.sv
`timescale 1ns/1ps
module tb_port2axis_arb;
    import port2axis_pkg::*;

    localparam int unsigned CH       = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned BP_SLACK = 4;

    typedef struct {
        fentry_t    e;
        logic [1:0] dest;
    } exp_t;

    typedef struct {
        int unsigned ch;
        int unsigned len;
        int          dest;
        int          lat;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    logic [CH-1:0][P2A_LANES-1:0][P2A_W-1:0] D;
    logic [CH-1:0] D_VALID;
    logic [CH-1:0] D_EOF;
    logic [CH-1:0] D_BP;
    logic [CH-1:0] OVF;
    flit_t         M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic [1:0]    M_AXIS_TDEST;
    logic          M_AXIS_TREADY;

    exp_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    port2axis_arb #(
        .CH       (CH),
        .LANES    (P2A_LANES),
        .W        (P2A_W),
        .DEPTH    (DEPTH),
        .BP_SLACK (BP_SLACK)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .D             (D),
        .D_VALID       (D_VALID),
        .D_EOF         (D_EOF),
        .D_BP          (D_BP),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TDEST  (M_AXIS_TDEST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .OVF           (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic flit_t mk_flit(input int unsigned ch, input int unsigned n);
        flit_t f;
        for (int unsigned l = 0; l < P2A_LANES; l++) begin
            f[l] = {8'(ch), 8'(l), 16'hA5C3, 32'(n)};
        end
        return f;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        D       = '0;
        D_VALID = '0;
        D_EOF   = '0;
    endtask

    task automatic present(input int unsigned ch, input int unsigned n, input logic eof);
        D[ch]       = mk_flit(ch, n);
        D_VALID[ch] = 1'b1;
        D_EOF[ch]   = eof;
    endtask

    task automatic push_exp(input int unsigned ch, input int unsigned n, input logic eof);
        exp_t x;
        x.e.eof  = eof;
        x.e.data = mk_flit(ch, n);
        x.dest   = 2'(ch);
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name, input int unsigned budget);
        for (int unsigned i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk_int(name, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Scoreboard on every accepted beat, plus AXIS hold-stability while stalled.
    initial begin : monitor
        logic       hold;
        flit_t      h_data;
        logic       h_last;
        logic [1:0] h_dest;
        exp_t       x;
        hold = 1'b0;
        h_data = '0;
        h_last = 1'b0;
        h_dest = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    n_checks++;
                    if (M_AXIS_TVALID === 1'b1 && M_AXIS_TDATA === h_data &&
                        M_AXIS_TLAST === h_last && M_AXIS_TDEST === h_dest) n_pass++;
                    else $display("FAIL axis_hold: got valid=%0b last=%0b dest=%0d, required valid=1 last=%0b dest=%0d, data changed=%0b (t=%0t)",
                                  M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDEST, h_last, h_dest,
                                  M_AXIS_TDATA !== h_data, $time);
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    chk_int("sb_has_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        x = exp_q.pop_front();
                        n_checks++;
                        if (M_AXIS_TDATA === x.e.data && M_AXIS_TLAST === x.e.eof &&
                            M_AXIS_TDEST === x.dest) n_pass++;
                        else $display("FAIL sb_beat: got last=%0b dest=%0d data=%0h, required last=%0b dest=%0d data=%0h",
                                      M_AXIS_TLAST, M_AXIS_TDEST, M_AXIS_TDATA,
                                      x.e.eof, x.dest, x.e.data);
                    end
                end
                hold   = M_AXIS_TVALID && !M_AXIS_TREADY;
                h_data = M_AXIS_TDATA;
                h_last = M_AXIS_TLAST;
                h_dest = M_AXIS_TDEST;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs [5];
        logic [7:0] pair_v;
        int   pair_d [8];
        int   first;
        int   tlast_at;
        int   gap_bad;

        vecs[0] = '{ch: 0, len: 3, dest: 0, lat: 2};
        vecs[1] = '{ch: 1, len: 1, dest: 1, lat: 2};
        vecs[2] = '{ch: 3, len: 4, dest: 3, lat: 2};
        vecs[3] = '{ch: 2, len: 2, dest: 2, lat: 2};
        vecs[4] = '{ch: 0, len: 1, dest: 0, lat: 2};
        // ch1 frame, one ARB bubble, ch2 frame (cycle 0 = both present first flit)
        pair_v = 8'b0110_1100;
        pair_d = '{0, 0, 1, 1, 0, 2, 2, 0};

        RST = 1'b1;
        M_AXIS_TREADY = 1'b0;
        clear_inputs();
        repeat (2) tick();
        chk_int("rst_tvalid", int'(M_AXIS_TVALID), 0);
        chk_int("rst_tlast",  int'(M_AXIS_TLAST), 0);
        chk_int("rst_tdata_zero", int'(M_AXIS_TDATA == '0), 1);
        chk_int("rst_tdest",  int'(M_AXIS_TDEST), 0);
        chk_int("rst_d_bp",   int'(D_BP), 0);
        chk_int("rst_ovf",    int'(OVF), 0);
        RST = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (2) tick();

        // Table of single-channel frames on an idle block: latency, TDEST, TLAST position.
        for (int v = 0; v < 5; v++) begin
            first    = -1;
            tlast_at = -1;
            for (int unsigned j = 0; j < vecs[v].ch * 0 + vecs[v].len + 4; j++) begin
                tick();
                clear_inputs();
                if (j < vecs[v].len) begin
                    present(vecs[v].ch, 100 * v + j, j == vecs[v].len - 1);
                    push_exp(vecs[v].ch, 100 * v + j, j == vecs[v].len - 1);
                end
                @(negedge CLK);
                if (first < 0 && M_AXIS_TVALID) begin
                    first = int'(j);
                    chk_int("vec_tdest", int'(M_AXIS_TDEST), vecs[v].dest);
                end
                if (tlast_at < 0 && M_AXIS_TVALID && M_AXIS_TLAST) tlast_at = int'(j);
            end
            tick();
            clear_inputs();
            chk_int("vec_latency", first, vecs[v].lat);
            chk_int("vec_tlast_cycle", tlast_at, vecs[v].lat + int'(vecs[v].len) - 1);
            drain("vec_drain", 40);
            chk_int("vec_ovf", int'(OVF), 0);
        end

        // ch1 and ch2 start on the same cycle: ch1 first, one idle cycle, then ch2.
        push_exp(1, 201, 1'b0);
        push_exp(1, 202, 1'b1);
        push_exp(2, 211, 1'b0);
        push_exp(2, 212, 1'b1);
        for (int unsigned j = 0; j < 8; j++) begin
            tick();
            clear_inputs();
            if (j == 0) begin
                present(1, 201, 1'b0);
                present(2, 211, 1'b0);
            end else if (j == 1) begin
                present(1, 202, 1'b1);
                present(2, 212, 1'b1);
            end
            @(negedge CLK);
            chk_int("pair_tvalid", int'(M_AXIS_TVALID), int'(pair_v[j]));
            if (pair_v[j]) chk_int("pair_tdest", int'(M_AXIS_TDEST), pair_d[j]);
        end
        tick();
        clear_inputs();
        drain("pair_drain", 20);

        // Stalled sink: 20 flits into ch0; BP rises when free hits BP_SLACK, 18+ dropped.
        M_AXIS_TREADY = 1'b0;
        for (int unsigned n = 1; n <= 17; n++) push_exp(0, 300 + n, n == 17);
        for (int unsigned j = 0; j < 20; j++) begin
            tick();
            clear_inputs();
            present(0, 300 + j + 1, j == 16);
            @(negedge CLK);
            if (j == 12) chk_int("bp_low_at_11_in_fifo", int'(D_BP[0]), 0);
            if (j == 13) chk_int("bp_high_at_12_in_fifo", int'(D_BP[0]), 1);
            if (j == 17) chk_int("ovf_clear_when_just_full", int'(OVF[0]), 0);
            if (j == 18) chk_int("ovf_set_on_drop", int'(OVF[0]), 1);
        end
        tick();
        clear_inputs();
        repeat (2) tick();
        chk_int("bp_stall_tvalid", int'(M_AXIS_TVALID), 1);
        M_AXIS_TREADY = 1'b1;
        drain("bp_drain", 60);
        chk_int("ovf_sticky", int'(OVF[0]), 1);
        chk_int("bp_release", int'(D_BP[0]), 0);

        // ch3 frame with a mid-frame gap; concurrent ch0 frame must wait for ch3 TLAST.
        push_exp(3, 401, 1'b0);
        push_exp(3, 402, 1'b0);
        push_exp(3, 403, 1'b1);
        push_exp(0, 411, 1'b0);
        push_exp(0, 412, 1'b1);
        gap_bad = 0;
        for (int unsigned j = 0; j < 14; j++) begin
            tick();
            clear_inputs();
            if (j == 0) present(3, 401, 1'b0);
            if (j == 1) begin
                present(3, 402, 1'b0);
                present(0, 411, 1'b0);
            end
            if (j == 2) present(0, 412, 1'b1);
            if (j == 12) present(3, 403, 1'b1);
            @(negedge CLK);
            if (j >= 5 && j <= 12 && M_AXIS_TVALID) gap_bad++;
        end
        tick();
        clear_inputs();
        chk_int("gap_tvalid_low", gap_bad, 0);
        drain("gap_drain", 30);

        // TREADY toggling every cycle across a 6-flit ch1 frame.
        for (int unsigned n = 0; n < 6; n++) push_exp(1, 500 + n, n == 5);
        for (int unsigned j = 0; j < 40; j++) begin
            tick();
            M_AXIS_TREADY = ~M_AXIS_TREADY;
            clear_inputs();
            if (j < 6) present(1, 500 + j, j == 5);
            @(negedge CLK);
            if (j >= 6 && exp_q.size() == 0) break;
        end
        tick();
        clear_inputs();
        M_AXIS_TREADY = 1'b1;
        drain("toggle_drain", 20);

        // Reset in the middle of a stalled ch2 frame; stale flits must not reappear.
        M_AXIS_TREADY = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            tick();
            clear_inputs();
            present(2, 601 + j, 1'b0);
        end
        tick();
        clear_inputs();
        @(negedge CLK);
        chk_int("pre_rst_tvalid", int'(M_AXIS_TVALID), 1);
        chk_int("pre_rst_ovf0", int'(OVF[0]), 1);
        tick();
        RST = 1'b1;
        #1;
        chk_int("rst_async_tvalid", int'(M_AXIS_TVALID), 0);
        chk_int("rst_async_d_bp", int'(D_BP), 0);
        chk_int("rst_async_ovf", int'(OVF), 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        M_AXIS_TREADY = 1'b1;
        tick();
        push_exp(2, 610, 1'b0);
        push_exp(2, 611, 1'b1);
        tick();
        present(2, 610, 1'b0);
        tick();
        clear_inputs();
        present(2, 611, 1'b1);
        tick();
        clear_inputs();
        drain("post_rst_drain", 20);
        chk_int("post_rst_ovf", int'(OVF), 0);
        chk_int("post_rst_idle", int'(M_AXIS_TVALID), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
